// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Latency: BIN_W clocks from the accepting edge to the done pulse; ready is low while busy.
// Backpressure: start is ignored while ready=0 (no queuing). Optional macro BIN2BCD_LZ_BLANK_EN adds leading-zero blanking.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    // Number of decimal digits needed to hold 2**w - 1.
    function automatic int digits_needed(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    generate
        if (BIN_W < 1 || BIN_W > 63) begin : g_bad_width
            $error("bin2bcd_seq: BIN_W must be in 1..63");
        end else if (DIGITS < digits_needed(BIN_W)) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state;
    logic [BIN_W-1:0]       shreg;
    logic [4*DIGITS-1:0]    scratch;
    logic [4*DIGITS-1:0]    adj;
    logic [4*DIGITS-1:0]    nxt_scratch;
    logic [CNT_W-1:0]       cnt;

    assign ready = (state == IDLE);

    // Add 3 to each digit >= 5, then shift the next binary bit in at the bottom.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        nxt_scratch = (adj << 1) | (4*DIGITS)'(shreg[BIN_W-1]);
    end

    // Conversion FSM: accept, BIN_W shift steps, publish result with a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= nxt_scratch;
                    shreg   <= shreg << 1;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd   <= nxt_scratch;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIN2BCD_LZ_BLANK_EN
    // Value 0 must still show one "0", so digit 0 is never blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_nxt;
    logic              zero_run;

    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (nxt_scratch[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_run;
        end
    end

    // Blank mask updates together with bcd on the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= BLANK_RST;
        end else if (state == SHIFT && cnt == CNT_W'(1)) begin
            blank <= blank_nxt;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;

`ifdef BIN2BCD_LZ_BLANK_EN
    localparam logic [4:0] BLANK_RST = 5'b11110;
`else
    localparam logic [4:0] BLANK_RST = 5'b00000;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [BIN_W-1:0]     bin;
    logic                 ready;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd;
    logic [DIGITS-1:0]    blank;

    int nchk = 0;
    int nerr = 0;

    logic [19:0] exp_bcd_q[$];
    logic [4:0]  exp_blank_q[$];
    logic [19:0] last_bcd;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: decimal digits by plain division.
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Reference: digit i blank iff the value has fewer than i+1 decimal digits.
    function automatic logic [4:0] ref_blank(input int v);
        logic [4:0] r;
        int         p;
        r = '0;
`ifdef BIN2BCD_LZ_BLANK_EN
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
`else
        p = v;
`endif
        return r;
    endfunction

    task automatic push_exp(input int v);
        exp_bcd_q.push_back(ref_bcd(v));
        exp_blank_q.push_back(ref_blank(v));
    endtask

    // Scoreboard monitor: every done pulse pops one expected result; bcd must hold otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_bcd = bcd;
        end else if (done) begin
            if (exp_bcd_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_unexpected_done: got bcd %0h expected no done", bcd);
            end else begin
                chk("sb_bcd", 32'(bcd), 32'(exp_bcd_q.pop_front()));
                chk("sb_blank", 32'(blank), 32'(exp_blank_q.pop_front()));
            end
            last_bcd = bcd;
        end else begin
            chk("bcd_hold", 32'(bcd), 32'(last_bcd));
        end
    end

    // Wait for done, counting edges after the accepting edge (bounded).
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!done && k < 40);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
    endtask

    // One conversion: start for one cycle, then garbage on bin while busy.
    task automatic conv(input int v);
        int k;
        wait_ready();
        @(negedge clk);
        start = 1'b1;
        bin   = 16'(v);
        push_exp(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 16'($urandom);
        wait_done(k);
        chk("latency", 32'(k), 32'(BIN_W));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int busy;
        int pulses;
        int v;

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_bcd",   32'(bcd),   32'd0);
        chk("rst_blank", 32'(blank), 32'(BLANK_RST));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // 1: zero
        conv(0);
        chk("t1_bcd",   32'(bcd),   32'h00000);
        chk("t1_blank", 32'(blank), 32'(ref_blank(0)));

        // 2: all ones
        conv(65535);
        chk("t2_bcd",   32'(bcd),   32'h65535);
        chk("t2_blank", 32'(blank), 32'd0);

        // 3: start while busy is ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd1234;
        push_exp(1234);
        @(posedge clk);
        #1;
        start = 1'b0;
        busy  = ready ? 1 : 0;
        k     = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (k == 2) begin
                start = 1'b1;
                bin   = 16'd999;
            end
            if (k == 15) start = 1'b0;
            if (!done && ready) busy++;
        end while (!done && k < 40);
        chk("t3_latency", 32'(k), 32'd16);
        chk("t3_ready_low", 32'(busy), 32'd0);
        chk("t3_bcd", 32'(bcd), 32'h01234);
`ifdef BIN2BCD_LZ_BLANK_EN
        chk("t3_blank", 32'(blank), 32'b10000);
`else
        chk("t3_blank", 32'(blank), 32'b00000);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("t3_no_extra", 32'(exp_bcd_q.size()), 32'd0);

        // 4: reset mid-conversion aborts it
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd777;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t4_ready", 32'(ready), 32'd1);
        chk("t4_done",  32'(done),  32'd0);
        chk("t4_bcd",   32'(bcd),   32'd0);
        chk("t4_blank", 32'(blank), 32'(BLANK_RST));
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("t4_no_done", 32'(pulses), 32'd0);
        conv(42);
        chk("t4_bcd42", 32'(bcd), 32'h00042);
`ifdef BIN2BCD_LZ_BLANK_EN
        chk("t4_blank42", 32'(blank), 32'b11100);
`else
        chk("t4_blank42", 32'(blank), 32'b00000);
`endif

        // 5: back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd100;
        push_exp(100);
        @(posedge clk);
        #1;
        wait_done(k);
        chk("t5_lat1", 32'(k), 32'd16);
        chk("t5_bcd1", 32'(bcd), 32'h00100);
        bin = 16'd200;
        push_exp(200);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t5_busy", 32'(ready), 32'd0);
        wait_done(k);
        chk("t5_lat2", 32'(k), 32'd16);
        chk("t5_bcd2", 32'(bcd), 32'h00200);

        // 6: random values
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       v = 0;
                1:       v = 65535;
                2:       v = $urandom_range(0, 99);
                3:       v = $urandom_range(0, 9999);
                default: v = $urandom_range(0, 65535);
            endcase
            conv(v);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 32'(exp_bcd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
